l2_req_arbiter: RTL

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

---
 rtl/cache_pkg.sv | 21 ++
 rtl/l2_req_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 16 +
 rtl/l2_req_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the L2 request arbiter slice.
// FSM encoding, requester indices and counter helper.
package cache_pkg;

    localparam int DEF_ADDR_W = 11;

    localparam int REQ_L1I = 0;
    localparam int REQ_L1D = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } arb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Requester and L2 handshake bundle for l2_req_arbiter.
// slave = arbiter view, master = requesters plus L2 model view.
interface l2_req_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic              resp_hit;
    logic              resp_err;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_resp_valid;
    logic              l2_resp_hit;

    modport slave (
        input  req_valid, req_addr0, req_addr1,
        input  l2_req_ready, l2_resp_valid, l2_resp_hit,
        output req_ready, resp_valid, resp_hit, resp_err,
        output l2_req_valid, l2_req_addr
    );

    modport master (
        output req_valid, req_addr0, req_addr1,
        output l2_req_ready, l2_resp_valid, l2_resp_hit,
        input  req_ready, resp_valid, resp_hit, resp_err,
        input  l2_req_valid, l2_req_addr
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates L1-I / L1-D misses onto one L2 port, one access in flight.
module l2_req_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    l2_req_arbiter_if.slave bus,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1,
    output logic [31:0] timeout_cnt
);
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    arb_state_t        state;
    logic [1:0]        grant;
    logic              last_grant;
    logic              gidx;
    logic              win;
    logic              hs;
    logic [8:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_sel;

    rr_arb2 u_rr (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready only leaves the block in IDLE, and never while in reset.
    assign bus.req_ready = (state == ST_IDLE && rst_n) ? grant : 2'b00;
    assign hs       = |(bus.req_valid & bus.req_ready);
    assign win      = grant[REQ_L1D];
    assign addr_sel = win ? bus.req_addr1 : bus.req_addr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            last_grant       <= 1'b1;
            gidx             <= 1'b0;
            wait_cnt         <= '0;
            grant_cnt0       <= '0;
            grant_cnt1       <= '0;
            timeout_cnt      <= '0;
            bus.resp_valid   <= 2'b00;
            bus.resp_hit     <= 1'b0;
            bus.resp_err     <= 1'b0;
            bus.l2_req_valid <= 1'b0;
            bus.l2_req_addr  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (hs) begin
                        gidx             <= win;
                        last_grant       <= win;
                        bus.l2_req_addr  <= addr_sel;
                        bus.l2_req_valid <= 1'b1;
                        if (win) grant_cnt1 <= sat_inc(grant_cnt1);
                        else     grant_cnt0 <= sat_inc(grant_cnt0);
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.l2_req_ready) begin
                        bus.l2_req_valid <= 1'b0;
                        wait_cnt         <= '0;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response landing on the timeout cycle takes priority.
                    if (bus.l2_resp_valid) begin
                        bus.resp_hit   <= bus.l2_resp_hit;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= gidx ? 2'b10 : 2'b01;
                        state          <= ST_RESPOND;
                    end else if (wait_cnt + 9'd1 == TO_LIM) begin
                        bus.resp_hit   <= 1'b0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= gidx ? 2'b10 : 2'b01;
                        timeout_cnt    <= sat_inc(timeout_cnt);
                        state          <= ST_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + 9'd1;
                    end
                end
                ST_RESPOND: begin
                    bus.resp_valid <= 2'b00;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
